alu_operand_seq: RTL and testbench
==================================

# alu_operand_seq

Pin-limited front end for the ALU logic datapath. It accepts a three-byte command stream (command, operand A, operand B) over an 8-bit valid/ready input channel and drives registered operands and opcode into the logic unit. It captures the unit's combinational result, adds status flags, and returns the result over a valid/ready output channel. It sits directly upstream of the logic unit and also consumes that unit's output.

## Interface

- `WIDTH`, 8: operand, result and input-byte width.
- `OPW`, 4: opcode width.
- `CLK` in, 1: single clock, rising edge.
- `RST_N` in, 1: asynchronous assert, active-low reset.
- `DIN` in, WIDTH: input byte.
- `DIN_VALID` in, 1: `DIN` is valid this cycle.
- `DIN_READY` out, 1: block accepts `DIN` this cycle.
- `OP_A` out, WIDTH: registered operand A to the logic unit.
- `OP_B` out, WIDTH: registered operand B to the logic unit.
- `OP_CODE` out, OPW: registered opcode to the logic unit.
- `Y_IN` in, WIDTH: logic unit result (combinational from `OP_A`/`OP_B`/`OP_CODE`).
- `DOUT` out, WIDTH: captured result.
- `FLAGS` out, 3: {P, N, Z}. Z = result is 0. N = result[WIDTH-1]. P = XOR-reduce of result.
- `ERR` out, 1: the returned response is a rejected command.
- `DOUT_VALID` out, 1: response valid.
- `DOUT_READY` in, 1: consumer accepts the response.
- `TXN_CNT` out, 8: count of completed responses, wraps 255→0.

## Operation

- A transfer occurs on a rising edge with VALID and READY both high, on either channel.
- Command byte layout: [OPW-1:0] = opcode, [7:OPW] = reserved and must be 0.
- FSM states: IDLE, GET_A, GET_B, EXEC, RESP.
  - IDLE: `DIN_READY`=1. On a transfer, latch `OP_CODE` ← DIN[3:0].
    - If DIN[7:4]≠0, set the error latch and go to RESP.
    - Otherwise clear the error latch and go to GET_A.
  - GET_A: `DIN_READY`=1. On a transfer, `OP_A` ← DIN, then go to GET_B.
  - GET_B: `DIN_READY`=1. On a transfer, `OP_B` ← DIN, then go to EXEC.
  - EXEC: `DIN_READY`=0. Result register ← `Y_IN` and flags register ← flags(`Y_IN`). Go to RESP.
  - RESP: `DOUT_VALID`=1 and `DIN_READY`=0. On an output transfer, `TXN_CNT`+1 and go to IDLE.
- Error response: `DOUT`=0, `FLAGS`=0, `ERR`=1. `OP_A`, `OP_B` and the result registers are unchanged from the previous command. The opcode register is overwritten. Error responses count in `TXN_CNT`.
- `OP_A`, `OP_B` and `OP_CODE` hold their values outside the load states. The logic unit output therefore stays stable through RESP.
- Idle cycles (`DIN_VALID`=0) between bytes are allowed. The FSM waits in the current state.
- `DOUT`, `FLAGS` and `ERR` are stable while `DOUT_VALID`=1 and `DOUT_READY`=0.
- Opcode values are passed through unchecked. The logic unit decodes only [1:0]: 00 AND, 01 OR, 10 XOR, 11 INV A.

## Timing

- Reset values: state IDLE; `DIN_READY`=1; `DOUT_VALID`=0; `OP_A`, `OP_B`, `OP_CODE`, `DOUT`, `FLAGS`, `ERR` and `TXN_CNT` all 0.
- With back-to-back input, the command is accepted in cycle 0, A in cycle 1, B in cycle 2. The capture edge is at the end of cycle 3, and `DOUT_VALID` is high from cycle 4.
- Minimum command-to-command period with `DOUT_READY` tied high: 5 cycles.
- Error path: command accepted in cycle 0, `DOUT_VALID` high in cycle 1.
- `DOUT_READY` has no combinational path to `DIN_READY`. A new command is accepted no earlier than the cycle after the response transfer.
- Reset asserted mid-command or mid-RESP returns all state to reset values immediately and abandons the transaction. The partial transaction is not counted.

## Structure

- Shared package `alu_pkg`:
  - state enum `seq_state_t`.
  - opcode constants `OP_AND`=4'h0, `OP_OR`=4'h1, `OP_XOR`=4'h2, `OP_INV`=4'h3.
  - flag index constants `FLG_Z`=0, `FLG_N`=1, `FLG_P`=2.
- Sub-module `alu_flag_gen`: combinational, WIDTH-bit result in, 3-bit flags out. It is reused by later ALU stages.
- The bench connects `OP_A`/`OP_B`/`OP_CODE`/`Y_IN` to the existing logic unit.

## Test plan

- Reset, then command 0x00, A=0xF0, B=0x3C, `DOUT_READY`=1 → cycle 4 gives `DOUT`=0x30, `FLAGS`=3'b000, `ERR`=0, `TXN_CNT`=1.
- Opcodes 0x01, 0x02, 0x03 with A=0xA5, B=0x0F → results 0xAF (N=1, P=0), 0xAA (N=1, P=0), 0x5A (N=0, P=0).
- XOR with A=B=0x77 → `DOUT`=0x00, Z=1. Next, AND 0x80,0x80 → 0x80, N=1, P=1.
- Command 0x31 → `ERR`=1 and `DOUT_VALID` in cycle 1. `OP_A`/`OP_B` are unchanged. The next valid command works normally.
- Stalls: random `DIN_VALID` gaps, and `DOUT_READY` held low for 10 cycles → `DOUT` stable, `DIN_READY`=0 throughout, exactly one count per response.
- Assert `RST_N` low after the A byte → all outputs return to reset values. Then 256 completed responses → `TXN_CNT` wraps to 0.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared types and constants for the ALU front end and later
//            ALU stages: sequencer state encoding, logic-unit opcodes and
//            the bit positions of the status flags.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

  // Command sequencer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GET_A = 3'd1,
    ST_GET_B = 3'd2,
    ST_EXEC  = 3'd3,
    ST_RESP  = 3'd4
  } seq_state_t;

  // Logic unit opcodes (unit decodes only bits [1:0])
  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_OR  = 4'h1;
  localparam logic [3:0] OP_XOR = 4'h2;
  localparam logic [3:0] OP_INV = 4'h3;

  // Bit positions inside the 3-bit {P, N, Z} flag vector
  localparam int FLG_Z = 0;
  localparam int FLG_N = 1;
  localparam int FLG_P = 2;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_flag_gen.sv
`default_nettype none
// ============================================================================
// Module   : alu_flag_gen
// Purpose  : Combinational status-flag generator for an ALU result.
//            Z = result is zero, N = result MSB, P = XOR-reduce of result.
// Ports    : result [WIDTH-1:0] in  - value to classify
//            flags  [2:0]       out - {P, N, Z}
// Revision : 1.0 - initial release
// ============================================================================
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] result,
  output logic [2:0]       flags
);

  always_comb begin
    flags        = '0;
    flags[FLG_Z] = (result == '0);
    flags[FLG_N] = result[WIDTH-1];
    flags[FLG_P] = ^result;
  end

endmodule : alu_flag_gen
`default_nettype wire

// File: rtl/alu_operand_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_operand_seq
// Purpose  : Pin-limited front end for the ALU logic unit. Collects a
//            three-byte command (opcode, A, B) over an 8-bit valid/ready
//            channel, drives registered operands/opcode into the logic unit,
//            captures its combinational result with status flags, and
//            returns it over a valid/ready response channel.
// Ports    : clk, rst_n            - clock, async active-low reset
//            din/din_valid/din_ready       - command byte input channel
//            op_a/op_b/op_code     - registered operands to the logic unit
//            y_in                  - logic unit result
//            dout/flags/err/dout_valid/dout_ready - response channel
//            txn_cnt               - completed responses, wraps at 256
// Revision : 1.0 - initial release
// ============================================================================
module alu_operand_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic [OPW-1:0]   op_code,
  input  logic [WIDTH-1:0] y_in,
  output logic [WIDTH-1:0] dout,
  output logic [2:0]       flags,
  output logic             err,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [7:0]       txn_cnt
);

  seq_state_t       r_state;
  logic             r_din_ready;
  logic             r_dout_valid;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [OPW-1:0]   r_op_code;
  logic [WIDTH-1:0] r_result;
  logic [2:0]       r_flags;
  logic             r_err;
  logic [7:0]       r_txn_cnt;

  logic [2:0]       w_flags;
  logic             w_in_xfer;
  logic             w_out_xfer;

  assign w_in_xfer  = din_valid & r_din_ready;
  assign w_out_xfer = r_dout_valid & dout_ready;

  alu_flag_gen #(
    .WIDTH (WIDTH)
  ) u_flag_gen (
    .result (y_in),
    .flags  (w_flags)
  );

  // din_ready and dout_valid are registered alongside the state so that
  // dout_ready never reaches din_ready combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_din_ready  <= 1'b1;
      r_dout_valid <= 1'b0;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_op_code    <= '0;
      r_result     <= '0;
      r_flags      <= '0;
      r_err        <= 1'b0;
      r_txn_cnt    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_in_xfer) begin
            r_op_code <= din[OPW-1:0];
            if (din[WIDTH-1:OPW] != '0) begin
              // Reserved bits set: reject without touching operands/result
              r_err        <= 1'b1;
              r_din_ready  <= 1'b0;
              r_dout_valid <= 1'b1;
              r_state      <= ST_RESP;
            end else begin
              r_err   <= 1'b0;
              r_state <= ST_GET_A;
            end
          end
        end

        ST_GET_A: begin
          if (w_in_xfer) begin
            r_op_a  <= din;
            r_state <= ST_GET_B;
          end
        end

        ST_GET_B: begin
          if (w_in_xfer) begin
            r_op_b      <= din;
            r_din_ready <= 1'b0;
            r_state     <= ST_EXEC;
          end
        end

        ST_EXEC: begin
          // Operands settled for a full cycle; sample the logic unit output
          r_result     <= y_in;
          r_flags      <= w_flags;
          r_dout_valid <= 1'b1;
          r_state      <= ST_RESP;
        end

        ST_RESP: begin
          if (w_out_xfer) begin
            r_txn_cnt    <= r_txn_cnt + 8'd1;
            r_dout_valid <= 1'b0;
            r_din_ready  <= 1'b1;
            r_state      <= ST_IDLE;
          end
        end

        default: begin
          r_din_ready  <= 1'b1;
          r_dout_valid <= 1'b0;
          r_state      <= ST_IDLE;
        end
      endcase
    end
  end

  // A rejected command reports zero data and flags while the result
  // registers keep the previous command's values.
  assign dout       = r_err ? '0 : r_result;
  assign flags      = r_err ? 3'b000 : r_flags;
  assign err        = r_err;
  assign din_ready  = r_din_ready;
  assign dout_valid = r_dout_valid;
  assign op_a       = r_op_a;
  assign op_b       = r_op_b;
  assign op_code    = r_op_code;
  assign txn_cnt    = r_txn_cnt;

endmodule : alu_operand_seq
`default_nettype wire

// File: tb/tb_alu_operand_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_operand_seq
// Purpose  : Self-checking bench for alu_operand_seq with a behavioural
//            logic unit closing the op_a/op_b/op_code -> y_in loop.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_operand_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic [3:0] op_code;
  logic [7:0] y_in;
  logic [7:0] dout;
  logic [2:0] flags;
  logic       err;
  logic       dout_valid;
  logic       dout_ready;
  logic [7:0] txn_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  logic [7:0] exp_cnt;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_operand_seq #(.WIDTH(8), .OPW(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .op_a       (op_a),
    .op_b       (op_b),
    .op_code    (op_code),
    .y_in       (y_in),
    .dout       (dout),
    .flags      (flags),
    .err        (err),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .txn_cnt    (txn_cnt)
  );

  // Logic unit: decodes opcode bits [1:0]
  function automatic logic [7:0] lu(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op[1:0])
      2'b00:   lu = a & b;
      2'b01:   lu = a | b;
      2'b10:   lu = a ^ b;
      default: lu = ~a;
    endcase
  endfunction

  function automatic logic [2:0] fl_model(input logic [7:0] y);
    fl_model = {^y, y[7], (y == 8'h00)};
  endfunction

  assign y_in = lu(op_code, op_a, op_b);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic fail_timeout(input string nm);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timed out, got no handshake, expected one within 50 cycles", nm);
  endtask

  // Called and returns at a negedge; leaves din_valid high.
  task automatic send_byte(input logic [7:0] b, input int gap, output int t_acc);
    int w;
    if (gap > 0) begin
      din_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    din       = b;
    din_valid = 1'b1;
    w = 0;
    while (!din_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!din_ready) fail_timeout("din_ready");
    t_acc = cyc;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Waits for the response, checks it, then completes the output transfer.
  task automatic get_resp(input logic [7:0] ey, input logic [2:0] ef, input logic ee,
                          input int t_acc, input int elat, input string nm);
    int w;
    din_valid  = 1'b0;
    dout_ready = 1'b1;
    w = 0;
    while (!dout_valid && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!dout_valid) begin
      fail_timeout({nm, "_dout_valid"});
    end else begin
      if (elat > 0) chk({nm, "_latency"}, cyc - t_acc, elat);
      chk({nm, "_dout"},  dout,  ey);
      chk({nm, "_flags"}, flags, ef);
      chk({nm, "_err"},   err,   ee);
      chk({nm, "_din_ready_in_resp"}, din_ready, 1'b0);
      @(posedge clk);
      @(negedge clk);
      exp_cnt = exp_cnt + 8'd1;
      chk({nm, "_txn_cnt"}, txn_cnt, exp_cnt);
      chk({nm, "_dout_valid_drop"}, dout_valid, 1'b0);
      chk({nm, "_din_ready_back"}, din_ready, 1'b1);
    end
  endtask

  // Full command; gap>=0 selects idle cycles before each byte.
  task automatic run_cmd(input logic [7:0] c, input logic [7:0] a, input logic [7:0] b,
                         input int gmax, input int elat, input string nm);
    int t0, t1;
    logic [7:0] ey;
    logic       ee;
    ee = (c[7:4] != 4'h0);
    send_byte(c, (gmax > 0) ? $urandom_range(0, gmax) : 0, t0);
    if (!ee) begin
      send_byte(a, (gmax > 0) ? $urandom_range(0, gmax) : 0, t1);
      send_byte(b, (gmax > 0) ? $urandom_range(0, gmax) : 0, t1);
    end
    ey = ee ? 8'h00 : lu(c[3:0], a, b);
    get_resp(ey, ee ? 3'b000 : fl_model(ey), ee, t0, elat, nm);
  endtask

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] y;
    logic [2:0] fl;
    logic       er;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int t0, t1;
    logic [7:0] pa, pb, ey;

    vecs[0] = '{8'h00, 8'hF0, 8'h3C, 8'h30, 3'b000, 1'b0};
    vecs[1] = '{8'h01, 8'hA5, 8'h0F, 8'hAF, 3'b010, 1'b0};
    vecs[2] = '{8'h02, 8'hA5, 8'h0F, 8'hAA, 3'b010, 1'b0};
    vecs[3] = '{8'h03, 8'hA5, 8'h0F, 8'h5A, 3'b000, 1'b0};
    vecs[4] = '{8'h02, 8'h77, 8'h77, 8'h00, 3'b001, 1'b0};
    vecs[5] = '{8'h00, 8'h80, 8'h80, 8'h80, 3'b110, 1'b0};
    vecs[6] = '{8'h31, 8'h00, 8'h00, 8'h00, 3'b000, 1'b1};
    vecs[7] = '{8'h01, 8'h12, 8'h34, 8'h36, 3'b000, 1'b0};

    rst_n      = 1'b0;
    din        = 8'h00;
    din_valid  = 1'b0;
    dout_ready = 1'b1;
    exp_cnt    = 8'h00;
    repeat (2) @(negedge clk);

    chk("rst_din_ready",  din_ready,  1'b1);
    chk("rst_dout_valid", dout_valid, 1'b0);
    chk("rst_operands",   {op_a, op_b, 4'h0, op_code}, 20'h0);
    chk("rst_dout",       {dout, 1'b0, flags, 3'b000, err}, 16'h0);
    chk("rst_txn_cnt",    txn_cnt, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back table vectors
    pa = 8'h00;
    pb = 8'h00;
    for (int i = 0; i < 8; i++) begin
      send_byte(vecs[i].cmd, 0, t0);
      if (!vecs[i].er) begin
        send_byte(vecs[i].a, 0, t1);
        send_byte(vecs[i].b, 0, t1);
        pa = vecs[i].a;
        pb = vecs[i].b;
      end
      get_resp(vecs[i].y, vecs[i].fl, vecs[i].er, t0, vecs[i].er ? 1 : 4,
               $sformatf("vec%0d", i));
      if (vecs[i].er) begin
        chk("err_op_a_kept",  op_a, pa);
        chk("err_op_b_kept",  op_b, pb);
        chk("err_op_code_ow", op_code, vecs[i].cmd[3:0]);
      end
    end

    // Random input gaps plus output stall of 10 cycles
    for (int k = 0; k < 3; k++)
      run_cmd(8'h02 ^ k[7:0], 8'h5C + k[7:0], 8'h3B, 3, 0, $sformatf("gap%0d", k));

    dout_ready = 1'b0;
    send_byte(8'h01, 2, t0);
    send_byte(8'h41, 1, t1);
    send_byte(8'h82, 3, t1);
    din_valid = 1'b0;
    ey = 8'h41 | 8'h82;
    begin
      int w;
      w = 0;
      while (!dout_valid && w < 50) begin
        @(negedge clk);
        w++;
      end
      if (!dout_valid) fail_timeout("stall_dout_valid");
    end
    for (int s = 0; s < 10; s++) begin
      chk("stall_dout",       dout,       ey);
      chk("stall_flags",      flags,      fl_model(ey));
      chk("stall_din_ready",  din_ready,  1'b0);
      chk("stall_dout_valid", dout_valid, 1'b1);
      chk("stall_txn_cnt",    txn_cnt,    exp_cnt);
      @(negedge clk);
    end
    dout_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    exp_cnt = exp_cnt + 8'd1;
    chk("stall_txn_once", txn_cnt, exp_cnt);
    @(negedge clk);
    chk("stall_txn_stays", txn_cnt, exp_cnt);

    // Reset after the A byte abandons the command
    send_byte(8'h02, 0, t0);
    send_byte(8'h99, 0, t1);
    rst_n     = 1'b0;
    din_valid = 1'b0;
    #1;
    chk("mid_rst_din_ready",  din_ready,  1'b1);
    chk("mid_rst_dout_valid", dout_valid, 1'b0);
    chk("mid_rst_operands",   {op_a, op_b, 4'h0, op_code}, 20'h0);
    chk("mid_rst_dout",       {dout, 1'b0, flags, 3'b000, err}, 16'h0);
    chk("mid_rst_txn_cnt",    txn_cnt, 8'h00);
    @(negedge clk);
    rst_n   = 1'b1;
    exp_cnt = 8'h00;
    @(negedge clk);

    // 256 responses wrap the counter back to zero
    for (int n = 0; n < 256; n++)
      run_cmd({6'h00, n[1:0]}, n[7:0], ~n[7:0], 0, 4, "wrap");
    chk("wrap_txn_zero", txn_cnt, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1);
  end

endmodule : tb_alu_operand_seq
`default_nettype wire
